alu_reg_sequencer: RTL

Microinstruction sequencer for the ALU/register-bank/RAM datapath.
- Accepts one microinstruction per valid/ready handshake.
- Drives the datapath select and opcode fields.
- Generates single-cycle latch, register-bank write and RAM write enables from one clock, replacing the separate CLK_LATCH/CLK_REGBANK/CLK_RAM strobes.
- Keeps an architectural carry flag between instructions.

---
 rtl/alu_reg_sequencer.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/alu_reg_sequencer.sv
// alu_reg_sequencer
// Microinstruction sequencer for the ALU / register-bank / RAM datapath.
// One microinstruction is accepted per handshake. Its fields are registered
// onto the datapath controls, held for SETTLE_CYCLES, then a single-cycle
// latch enable fires, followed by a single-cycle write cycle (register bank
// and/or RAM write enables plus a done pulse). A carry flag is kept between
// instructions.
//
// Handshake: UI_VALID/UI_READY. A transfer happens on the rising CLK edge
// where both are high. UI_READY is high only in IDLE (and never during or
// right at reset) and does not depend on UI_VALID. The fields are sampled
// only at the transfer edge; later changes on UI_* are ignored.
//
// Ports:
//   CLK, RST_N                clock (rising edge), async active-low reset
//   UI_VALID / UI_READY       microinstruction handshake
//   UI_SEL_A/B, UI_C_SEL      operand/destination register selects
//   UI_ALUC, UI_SHIFT         ALU opcode, shifter select
//   UI_KMX_SEL, UI_KMX        constant operand select and value
//   UI_USE_CY                 feed the carry flag into the ALU
//   UI_WB, UI_RAM_WE          write result to register bank / RAM
//   UI_RAM_ADDR               RAM address
//   CY_OUT                    ALU carry out
//   SEL_A_RB .. RAM_ADDR      registered datapath controls
//   CY_IN                     carry into the ALU
//   LATCH_EN, REGBANK_WE,
//   RAM_WE, UI_DONE           one-cycle pulses
//   CY_FLAG                   architectural carry flag
//   INSTR_CNT, BUSY_CNT       performance counters (only with SEQ_PERF_CNT_EN)
//   state_dbg                 current FSM state (IDLE=0 SETTLE=1 LATCH=2 WRITE=3)
//
// Optional feature macro: SEQ_PERF_CNT_EN adds INSTR_CNT and BUSY_CNT.

module alu_reg_sequencer #(
  parameter int DATA_W        = 16,
  parameter int SEL_W         = 6,
  parameter int ADDR_W        = 10,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              UI_VALID,
  output logic              UI_READY,
  input  logic [SEL_W-1:0]  UI_SEL_A,
  input  logic [SEL_W-1:0]  UI_SEL_B,
  input  logic [SEL_W-1:0]  UI_C_SEL,
  input  logic [3:0]        UI_ALUC,
  input  logic [1:0]        UI_SHIFT,
  input  logic              UI_KMX_SEL,
  input  logic [DATA_W-1:0] UI_KMX,
  input  logic              UI_USE_CY,
  input  logic              UI_WB,
  input  logic              UI_RAM_WE,
  input  logic [ADDR_W-1:0] UI_RAM_ADDR,
  input  logic              CY_OUT,
  output logic [SEL_W-1:0]  SEL_A_RB,
  output logic [SEL_W-1:0]  SEL_B_RB,
  output logic [SEL_W-1:0]  C_SEL_RB,
  output logic [3:0]        ALUC_IN,
  output logic [1:0]        SHIFTER_SEL,
  output logic              Y_X_KMX_SEL,
  output logic [DATA_W-1:0] Y_KMX,
  output logic [ADDR_W-1:0] RAM_ADDR,
  output logic              CY_IN,
  output logic              LATCH_EN,
  output logic              REGBANK_WE,
  output logic              RAM_WE,
  output logic              CY_FLAG,
  output logic              UI_DONE,
`ifdef SEQ_PERF_CNT_EN
  output logic [15:0]       INSTR_CNT,
  output logic [15:0]       BUSY_CNT,
`endif
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    LATCH  = 2'd2,
    WRITE  = 2'd3
  } state_t;

  state_t     state, state_nx;
  logic [3:0] cnt, cnt_nx;
  // Set on the first clock edge after reset release; keeps UI_READY low
  // while reset is asserted even though the state is already IDLE.
  logic       run_q;
  logic       wb_q, ram_we_q, use_cy_q;
  logic       accept;

  assign accept    = UI_VALID && UI_READY;
  assign state_dbg = state;
  assign CY_IN     = use_cy_q & CY_FLAG;

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    UI_READY   = 1'b0;
    LATCH_EN   = 1'b0;
    REGBANK_WE = 1'b0;
    RAM_WE     = 1'b0;
    UI_DONE    = 1'b0;
    case (state)
      IDLE: begin
        UI_READY = run_q;
        if (UI_VALID && run_q) begin
          state_nx = SETTLE;
          cnt_nx   = 4'(SETTLE_CYCLES);
        end
      end
      SETTLE: begin
        // Loaded with SETTLE_CYCLES, leaves when it reads 1: exactly
        // SETTLE_CYCLES cycles spent here.
        if (cnt <= 4'd1) state_nx = LATCH;
        else             cnt_nx   = cnt - 4'd1;
      end
      LATCH: begin
        LATCH_EN = 1'b1;
        state_nx = WRITE;
      end
      WRITE: begin
        REGBANK_WE = wb_q;
        RAM_WE     = ram_we_q;
        UI_DONE    = 1'b1;
        state_nx   = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state       <= IDLE;
      cnt         <= '0;
      run_q       <= 1'b0;
      wb_q        <= 1'b0;
      ram_we_q    <= 1'b0;
      use_cy_q    <= 1'b0;
      CY_FLAG     <= 1'b0;
      SEL_A_RB    <= '0;
      SEL_B_RB    <= '0;
      C_SEL_RB    <= '0;
      ALUC_IN     <= '0;
      SHIFTER_SEL <= '0;
      Y_X_KMX_SEL <= 1'b0;
      Y_KMX       <= '0;
      RAM_ADDR    <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      run_q <= 1'b1;
      // Controls stay at their last value in IDLE to avoid datapath toggling.
      if (accept) begin
        SEL_A_RB    <= UI_SEL_A;
        SEL_B_RB    <= UI_SEL_B;
        C_SEL_RB    <= UI_C_SEL;
        ALUC_IN     <= UI_ALUC;
        SHIFTER_SEL <= UI_SHIFT;
        Y_X_KMX_SEL <= UI_KMX_SEL;
        Y_KMX       <= UI_KMX;
        RAM_ADDR    <= UI_RAM_ADDR;
        wb_q        <= UI_WB;
        ram_we_q    <= UI_RAM_WE;
        use_cy_q    <= UI_USE_CY;
      end
      // Carry is captured at the end of the latch cycle whether or not the
      // instruction consumed it.
      if (state == LATCH) CY_FLAG <= CY_OUT;
    end
  end

`ifdef SEQ_PERF_CNT_EN
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      INSTR_CNT <= '0;
      BUSY_CNT  <= '0;
    end else begin
      if (UI_DONE)       INSTR_CNT <= INSTR_CNT + 16'd1;
      if (state != IDLE) BUSY_CNT  <= BUSY_CNT + 16'd1;
    end
  end
`endif

endmodule
